// File: rtl/if_id_ex_pipe_pkg.sv
// Shared definitions for the IF/ID + ID/EX pipeline registers.
// Holds the NOP encoding, ctrl field layout, counter width and stage record types.
// No logic lives here apart from the saturating-increment helper.
package if_id_ex_pipe_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;  // addi x0, x0, 0
    localparam int          CNT_W    = 16;
    localparam int          CTRL_W   = 12;

    // Field layout of ctrl_ID/ctrl_EX, MSB first.
    // Bit offsets: rf_we=11, wd_sel=10:9, alu_op=8:5, alub_sel=4, dram_we=3, br_type=2:0.
    typedef struct packed {
        logic       rf_we;
        logic [1:0] wd_sel;
        logic [3:0] alu_op;
        logic       alub_sel;
        logic       dram_we;
        logic [2:0] br_type;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
    } if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] ext;
        logic [4:0]  wr;
        ctrl_t       ctrl;
        logic        valid;
    } id_ex_t;

    localparam int IF_ID_W = $bits(if_id_t);
    localparam int ID_EX_W = $bits(id_ex_t);

    // IF/ID bubble: NOP instruction, zero PCs, not valid.
    localparam if_id_t IF_ID_BUBBLE = '{inst: NOP_INST, pc: 32'h0, pc4: 32'h0, valid: 1'b0};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/if_id_ex_pipe_if.sv
// Bundle of all non-clock signals of the IF/ID/EX pipeline registers.
// master = the surrounding core (drives IF/ID-stage data and hazard controls),
// slave  = the pipeline register block (drives ID/EX-stage contents and counters).
interface if_id_ex_pipe_if;
    import if_id_ex_pipe_pkg::*;

    logic              keep_IF_ID;
    logic              flush_IF_ID;
    logic              flush_ID_EX;
    logic              clr_cnt;
    logic [31:0]       pc_IF;
    logic [31:0]       pc4_IF;
    logic [31:0]       inst_IF;
    logic [31:0]       rD1_ID;
    logic [31:0]       rD2_ID;
    logic [31:0]       ext_ID;
    logic [4:0]        wR_ID;
    logic [CTRL_W-1:0] ctrl_ID;

    logic [31:0]       inst_ID;
    logic [31:0]       pc_ID;
    logic [31:0]       pc4_ID;
    logic              valid_ID;
    logic [31:0]       pc_EX;
    logic [31:0]       pc4_EX;
    logic [31:0]       rD1_EX;
    logic [31:0]       rD2_EX;
    logic [31:0]       ext_EX;
    logic [4:0]        wR_EX;
    logic [CTRL_W-1:0] ctrl_EX;
    logic              valid_EX;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output keep_IF_ID, flush_IF_ID, flush_ID_EX, clr_cnt,
        output pc_IF, pc4_IF, inst_IF, rD1_ID, rD2_ID, ext_ID, wR_ID, ctrl_ID,
        input  inst_ID, pc_ID, pc4_ID, valid_ID,
        input  pc_EX, pc4_EX, rD1_EX, rD2_EX, ext_EX, wR_EX, ctrl_EX, valid_EX,
        input  stall_cnt, flush_cnt
    );

    modport slave (
        input  keep_IF_ID, flush_IF_ID, flush_ID_EX, clr_cnt,
        input  pc_IF, pc4_IF, inst_IF, rD1_ID, rD2_ID, ext_ID, wR_ID, ctrl_ID,
        output inst_ID, pc_ID, pc4_ID, valid_ID,
        output pc_EX, pc4_EX, rD1_EX, rD2_EX, ext_EX, wR_EX, ctrl_EX, valid_EX,
        output stall_cnt, flush_cnt
    );
endinterface

// File: rtl/if_id_ex_pipe_stage_reg.sv
// Generic pipeline stage register with hold and bubble insertion.
// Latency: 1 cycle, registered output only. Priority flush_i > keep_i > load of d_i.
// Ports: clk, rst_n, keep_i (hold), flush_i (load FLUSH_VAL), d_i, q_o; reset loads RST_VAL.
module pipe_stage_reg #(
    parameter int           W         = 32,
    parameter logic [W-1:0] RST_VAL   = '0,
    parameter logic [W-1:0] FLUSH_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         keep_i,
    input  logic         flush_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = d_i;
        if (flush_i) begin
            q_d = FLUSH_VAL;
        end else if (keep_i) begin
            q_d = q_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;
endmodule

// File: rtl/if_id_ex_pipe.sv
// IF/ID and ID/EX pipeline registers with hazard controls and saturating stall/flush counters.
// Latency: 1 cycle per register; all outputs come straight from flops.
// Hold: keep_IF_ID freezes IF/ID only; flush_* insert bubbles; flush_IF_ID beats keep_IF_ID.
// Ports: clk, rst_n (async active-low), bus (slave modport carrying all data, controls, counters).
module if_id_ex_pipe
    import if_id_ex_pipe_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    if_id_ex_pipe_if.slave bus
);
    if_id_t            if_id_d;
    if_id_t            if_id_q;
    id_ex_t            id_ex_d;
    id_ex_t            id_ex_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q;
    logic [CNT_W-1:0]  flush_cnt_d;

    assign if_id_d = '{inst: bus.inst_IF, pc: bus.pc_IF, pc4: bus.pc4_IF, valid: 1'b1};

    pipe_stage_reg #(
        .W         (IF_ID_W),
        .RST_VAL   (IF_ID_BUBBLE),
        .FLUSH_VAL (IF_ID_BUBBLE)
    ) u_if_id (
        .clk     (clk),
        .rst_n   (rst_n),
        .keep_i  (bus.keep_IF_ID),
        .flush_i (bus.flush_IF_ID),
        .d_i     (if_id_d),
        .q_o     (if_id_q)
    );

    // PCs and valid come from the IF/ID register itself; operands come from ID-stage logic.
    assign id_ex_d = '{pc:    if_id_q.pc,
                       pc4:   if_id_q.pc4,
                       rd1:   bus.rD1_ID,
                       rd2:   bus.rD2_ID,
                       ext:   bus.ext_ID,
                       wr:    bus.wR_ID,
                       ctrl:  ctrl_t'(bus.ctrl_ID),
                       valid: if_id_q.valid};

    // An all-zero bubble clears rf_we/dram_we/br_type so nothing downstream has side effects.
    pipe_stage_reg #(
        .W         (ID_EX_W),
        .RST_VAL   ('0),
        .FLUSH_VAL ('0)
    ) u_id_ex (
        .clk     (clk),
        .rst_n   (rst_n),
        .keep_i  (1'b0),
        .flush_i (bus.flush_ID_EX),
        .d_i     (id_ex_d),
        .q_o     (id_ex_q)
    );

    // A stall only counts when it actually holds IF/ID, i.e. is not overridden by a flush.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (bus.clr_cnt) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (bus.keep_IF_ID && !bus.flush_IF_ID) begin
                stall_cnt_d = sat_inc(stall_cnt_q);
            end
            if (bus.flush_IF_ID) begin
                flush_cnt_d = sat_inc(flush_cnt_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.inst_ID   = if_id_q.inst;
    assign bus.pc_ID     = if_id_q.pc;
    assign bus.pc4_ID    = if_id_q.pc4;
    assign bus.valid_ID  = if_id_q.valid;
    assign bus.pc_EX     = id_ex_q.pc;
    assign bus.pc4_EX    = id_ex_q.pc4;
    assign bus.rD1_EX    = id_ex_q.rd1;
    assign bus.rD2_EX    = id_ex_q.rd2;
    assign bus.ext_EX    = id_ex_q.ext;
    assign bus.wR_EX     = id_ex_q.wr;
    assign bus.ctrl_EX   = id_ex_q.ctrl;
    assign bus.valid_EX  = id_ex_q.valid;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_if_id_ex_pipe.sv
// Bench for if_id_ex_pipe: directed hazard scenarios, counter saturation and async reset.
// A behavioural model tracks what each output must hold and is compared every falling edge;
// literal checks at key points pin both the model and the DUT.
module tb_if_id_ex_pipe;
    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    bit   cmp_en   = 0;

    if_id_ex_pipe_if bus();

    if_id_ex_pipe dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [31:0] m_inst_id, m_pc_id, m_pc4_id;
    logic        m_vld_id;
    logic [31:0] m_pc_ex, m_pc4_ex, m_rd1_ex, m_rd2_ex, m_ext_ex;
    logic [4:0]  m_wr_ex;
    logic [11:0] m_ctrl_ex;
    logic        m_vld_ex;
    int          m_stall, m_flush;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_inst_id = 32'h13; m_pc_id = 0; m_pc4_id = 0; m_vld_id = 0;
            m_pc_ex = 0; m_pc4_ex = 0; m_rd1_ex = 0; m_rd2_ex = 0; m_ext_ex = 0;
            m_wr_ex = 0; m_ctrl_ex = 0; m_vld_ex = 0;
            m_stall = 0; m_flush = 0;
        end else begin
            // ID/EX sees the IF/ID contents from before this edge.
            if (bus.flush_ID_EX) begin
                m_pc_ex = 0; m_pc4_ex = 0; m_rd1_ex = 0; m_rd2_ex = 0; m_ext_ex = 0;
                m_wr_ex = 0; m_ctrl_ex = 0; m_vld_ex = 0;
            end else begin
                m_pc_ex = m_pc_id; m_pc4_ex = m_pc4_id; m_vld_ex = m_vld_id;
                m_rd1_ex = bus.rD1_ID; m_rd2_ex = bus.rD2_ID; m_ext_ex = bus.ext_ID;
                m_wr_ex = bus.wR_ID; m_ctrl_ex = bus.ctrl_ID;
            end
            if (bus.flush_IF_ID) begin
                m_inst_id = 32'h13; m_pc_id = 0; m_pc4_id = 0; m_vld_id = 0;
            end else if (!bus.keep_IF_ID) begin
                m_inst_id = bus.inst_IF; m_pc_id = bus.pc_IF; m_pc4_id = bus.pc4_IF; m_vld_id = 1;
            end
            if (bus.clr_cnt) begin
                m_stall = 0; m_flush = 0;
            end else begin
                if (bus.keep_IF_ID && !bus.flush_IF_ID && m_stall < 65535) m_stall = m_stall + 1;
                if (bus.flush_IF_ID && m_flush < 65535) m_flush = m_flush + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_if_id", {bus.inst_ID, bus.pc_ID, bus.pc4_ID, bus.valid_ID},
                {m_inst_id, m_pc_id, m_pc4_id, m_vld_id});
            chk("model_id_ex", {bus.pc_EX, bus.pc4_EX, bus.rD1_EX, bus.rD2_EX, bus.ext_EX,
                                bus.wR_EX, bus.ctrl_EX, bus.valid_EX},
                {m_pc_ex, m_pc4_ex, m_rd1_ex, m_rd2_ex, m_ext_ex, m_wr_ex, m_ctrl_ex, m_vld_ex});
            chk("model_cnt", {bus.stall_cnt, bus.flush_cnt}, {m_stall[15:0], m_flush[15:0]});
        end
    end

    // Advance n edges; inputs change 1 time unit after each edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_ctl();
        bus.keep_IF_ID = 0; bus.flush_IF_ID = 0; bus.flush_ID_EX = 0; bus.clr_cnt = 0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst_n = 0;
        clear_ctl();
        bus.pc_IF = 0; bus.pc4_IF = 0; bus.inst_IF = 0;
        bus.rD1_ID = 0; bus.rD2_ID = 0; bus.ext_ID = 0; bus.wR_ID = 0; bus.ctrl_ID = 0;
        step(2);
        cmp_en = 1;

        // Reset values.
        chk("rst_inst_ID", bus.inst_ID, 32'h13);
        chk("rst_valids", {bus.valid_ID, bus.valid_EX}, 2'b00);
        chk("rst_cnts", {bus.stall_cnt, bus.flush_cnt}, 32'h0);
        chk("rst_ctrl_EX", bus.ctrl_EX, 12'h0);

        // Load sequence.
        rst_n = 1;
        bus.inst_IF = 32'h0050_0093; bus.pc_IF = 32'h0; bus.pc4_IF = 32'h4;
        step(1);
        chk("load_inst_ID", bus.inst_ID, 32'h0050_0093);
        chk("load_valid_ID", bus.valid_ID, 1'b1);
        bus.ctrl_ID = 12'h9C5; bus.rD1_ID = 32'h1111; bus.rD2_ID = 32'h2222;
        bus.ext_ID = 32'h5; bus.wR_ID = 5'd1;
        step(1);
        chk("load_ctrl_EX", bus.ctrl_EX, 12'h9C5);
        chk("load_wr_pc4_EX", {bus.wR_EX, bus.pc4_EX, bus.valid_EX}, {5'd1, 32'h4, 1'b1});

        // Load-use: hold IF/ID, bubble ID/EX.
        bus.inst_IF = 32'h00a0_0113; bus.pc_IF = 32'h4; bus.pc4_IF = 32'h8;
        bus.keep_IF_ID = 1; bus.flush_ID_EX = 1;
        step(1);
        chk("lu_inst_ID", bus.inst_ID, 32'h0050_0093);
        chk("lu_ctrl_valid_EX", {bus.ctrl_EX, bus.valid_EX}, 13'h0);
        chk("lu_stall_cnt", bus.stall_cnt, 16'd1);
        clear_ctl();
        bus.ctrl_ID = 12'hA5B;
        step(1);
        chk("lu_resume_inst_ID", bus.inst_ID, 32'h00a0_0113);
        chk("lu_resume_EX", {bus.ctrl_EX, bus.valid_EX}, {12'hA5B, 1'b1});

        // Taken branch: bubble both.
        bus.inst_IF = 32'h0000_0063; bus.pc_IF = 32'h8; bus.pc4_IF = 32'hC;
        bus.flush_IF_ID = 1; bus.flush_ID_EX = 1;
        step(1);
        chk("br_inst_ID", bus.inst_ID, 32'h13);
        chk("br_valids", {bus.valid_ID, bus.valid_EX}, 2'b00);
        chk("br_flush_cnt", bus.flush_cnt, 16'd1);
        clear_ctl();
        bus.inst_IF = 32'h0020_8193; bus.pc_IF = 32'h20; bus.pc4_IF = 32'h24;
        step(1);
        chk("br_bubble_EX", {bus.valid_EX, bus.pc_EX}, 33'h0);

        // Flush versus keep on IF/ID: flush wins, no stall counted.
        bus.flush_IF_ID = 1; bus.keep_IF_ID = 1;
        step(1);
        chk("cf_inst_ID", {bus.inst_ID, bus.valid_ID}, {32'h13, 1'b0});
        chk("cf_cnts", {bus.stall_cnt, bus.flush_cnt}, {16'd1, 16'd2});
        clear_ctl();
        step(1);

        // Clear, then saturate the stall counter.
        bus.clr_cnt = 1;
        step(1);
        chk("clr_cnts", {bus.stall_cnt, bus.flush_cnt}, 32'h0);
        clear_ctl();
        bus.keep_IF_ID = 1;
        step(70000);
        chk("sat_stall_cnt", bus.stall_cnt, 16'hFFFF);
        bus.clr_cnt = 1;
        step(1);
        chk("sat_clr_wins", bus.stall_cnt, 16'h0);
        bus.clr_cnt = 0;
        step(1);
        clear_ctl();
        step(2);
        chk("pre_rst_valid_EX", bus.valid_EX, 1'b1);

        // Async reset between edges.
        #2 rst_n = 0;
        #1;
        chk("arst_inst_ID", bus.inst_ID, 32'h13);
        chk("arst_outputs", {bus.valid_ID, bus.valid_EX, bus.pc_ID, bus.pc_EX, bus.ctrl_EX,
                             bus.stall_cnt}, 94'h0);
        step(1);
        rst_n = 1;
        bus.inst_IF = 32'h0010_8093; bus.pc_IF = 32'h40; bus.pc4_IF = 32'h44;
        step(1);
        chk("post_rst_load", {bus.inst_ID, bus.pc_ID, bus.valid_ID}, {32'h0010_8093, 32'h40, 1'b1});
        step(2);

        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
